div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/div_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the restoring divider sequencer:
// state encodings, step count and handshake levels.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_DIVZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam int   DIV_STEPS     = 32;

  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o,
  output logic         qbit_o
);

  logic [W:0] shl;

  // When shl >= dvs the true difference is below dvs,
  // so a W-bit subtract yields the exact remainder.
  always_comb begin
    shl    = {rem_i, dvd_i[W-1]};
    qbit_o = (shl >= {1'b0, dvs_i});
    rem_o  = qbit_o ? (shl[W-1:0] - dvs_i) : shl[W-1:0];
    dvd_o  = {dvd_i[W-2:0], 1'b0};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer beside EX: one quotient bit
// per cycle, stalls the pipe until {HI,LO} is ready.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_STEPS,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                annul_i,
  input  logic [DATA_W-1:0]   dividend_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_req_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_q, sgn_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   rem_s, dvd_s;
  logic                qbit_s;
  logic [DATA_W-1:0]   q_fin, r_fin;
  logic                neg_a_in, neg_b_in;

  div_step #(.W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dvs_i  (dvs_q),
    .rem_o  (rem_s),
    .dvd_o  (dvd_s),
    .qbit_o (qbit_s)
  );

  always_comb begin
    neg_a_in = signed_i & dividend_i[DATA_W-1];
    neg_b_in = signed_i & divisor_i[DATA_W-1];
    q_fin = (sgn_q & (neg_a_q ^ neg_b_q)) ? -dvd_q : dvd_q;
    r_fin = (sgn_q & neg_a_q) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    ready_d  = ready_q;
    if (annul_i) begin
      state_d  = DIV_IDLE;
      ready_d  = DIV_NOT_READY;
      result_d = '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start_i == DIV_START) begin
            sgn_d   = signed_i;
            neg_a_d = dividend_i[DATA_W-1];
            neg_b_d = divisor_i[DATA_W-1];
            dvd_d   = neg_a_in ? -dividend_i : dividend_i;
            dvs_d   = neg_b_in ? -divisor_i : divisor_i;
            cnt_d   = '0;
            rem_d   = '0;
            state_d = (divisor_i == '0) ? DIV_DIVZERO : DIV_ON;
          end
        end
        DIV_DIVZERO: begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_READY;
        end
        DIV_ON: begin
          if (cnt_q < CNT_W'(DATA_W)) begin
            rem_d = rem_s;
            dvd_d = dvd_s | {{(DATA_W-1){1'b0}}, qbit_s};
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d  = DIV_END;
            result_d = {r_fin, q_fin};
            ready_d  = DIV_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_d  = DIV_IDLE;
            ready_d  = DIV_NOT_READY;
            result_d = '0;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  // Reset also drops the stall so the pipe is never held in reset.
  assign stall_req_o = rst_n & start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed and random divides against
// a transaction-level reference with a per-cycle compare.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  int n_pass  = 0;
  int n_total = 0;

  div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: accept, count down latency, publish.
  logic        m_ready;
  logic [63:0] m_result;
  logic [63:0] m_pend;
  bit          m_busy;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  = 1'b0;
      m_result = 64'd0;
      m_busy   = 1'b0;
      m_left   = 0;
    end else if (annul_i) begin
      m_ready  = 1'b0;
      m_result = 64'd0;
      m_busy   = 1'b0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready  = 1'b0;
        m_result = 64'd0;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_ready  = 1'b1;
        m_result = m_pend;
        m_busy   = 1'b0;
      end
    end else if (start_i) begin
      m_busy = 1'b1;
      m_pend = ref_div(dividend_i, divisor_i, signed_i);
      m_left = (divisor_i == 32'd0) ? 1 : 33;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = rst_n & start_i & ~m_ready & ~annul_i;
    chk(result_o === m_result, "cyc_result", result_o, m_result);
    chk(ready_o === m_ready, "cyc_ready", 64'(ready_o), 64'(m_ready));
    chk(stall_req_o === exp_stall, "cyc_stall",
        64'(stall_req_o), 64'(exp_stall));
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp,
                        input int lat, input int hold, input string nm);
    int n;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom);
      end
    end while (!ready_o && n < 60);
    chk(ready_o === 1'b1, {nm, "_ready"}, 64'(ready_o), 64'd1);
    chk(n == lat, {nm, "_latency"}, 64'(n), 64'(lat));
    chk(result_o === exp, nm, result_o, exp);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk(result_o === exp && ready_o === 1'b1, {nm, "_hold"},
          result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk(ready_o === 1'b0 && result_o === 64'd0, {nm, "_release"},
        {result_o[62:0], ready_o}, 64'd0);
  endtask

  task automatic do_annul(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int k, input string nm);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    repeat (k) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    chk(ready_o === 1'b0 && result_o === 64'd0, nm,
        {result_o[62:0], ready_o}, 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op(input int kind);
    logic [31:0] v;
    v = $urandom;
    case (kind)
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = v & 32'h0000_00FF;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    annul_i    = 1'b0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk(ready_o === 1'b0 && result_o === 64'd0 && stall_req_o === 1'b0,
        "reset_state", {result_o[61:0], ready_o, stall_req_o}, 64'd0);
    rst_n = 1'b1;

    chk(ref_div(32'd100, 32'd7, 1'b0) == 64'h00000002_0000000E,
        "model_divu", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    chk(ref_div(32'hFFFFFFF9, 32'd2, 1'b1) == 64'hFFFFFFFF_FFFFFFFD,
        "model_div_neg", ref_div(32'hFFFFFFF9, 32'd2, 1'b1),
        64'hFFFFFFFF_FFFFFFFD);
    chk(ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1) == 64'h00000000_80000000,
        "model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1),
        64'h00000000_80000000);

    @(posedge clk); #1;
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 0, "divu_100_7");
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 0, "div_m7_2");
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 34, 0, "div_7_m2");
    do_div(32'd5, 32'd0, 1'b1, 64'd0, 2, 0, "div_by_zero");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, 0,
           "div_overflow");
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 34, 5,
           "divu_max_hold");

    do_annul(32'd1000, 32'd3, 1'b0, 11, "annul_step10");
    do_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 34, 0,
           "after_annul");

    for (int i = 0; i < 24; i++) begin
      a = rnd_op(int'($urandom_range(1, 7)));
      b = rnd_op(int'($urandom_range(0, 9)));
      s = 1'($urandom);
      if (i % 6 == 5)
        do_annul(a, b, s, int'($urandom_range(1, 36)), "annul_rand");
      else
        do_div(a, b, s, ref_div(a, b, s), (b == 32'd0) ? 2 : 34,
               int'($urandom_range(0, 3)), "rand_div");
    end

    // Async reset mid-computation, away from the clock edge.
    dividend_i = 32'd12345;
    divisor_i  = 32'd17;
    signed_i   = 1'b0;
    start_i    = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk(ready_o === 1'b0 && result_o === 64'd0 && stall_req_o === 1'b0,
        "reset_mid_on", {result_o[61:0], ready_o, stall_req_o}, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset while the result is being held.
    dividend_i = 32'd12345;
    divisor_i  = 32'd17;
    start_i    = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    chk(ready_o === 1'b1 && result_o === 64'h00000003_000002D6,
        "pre_reset_end", result_o, 64'h00000003_000002D6);
    #2;
    rst_n = 1'b0;
    #1;
    chk(ready_o === 1'b0 && result_o === 64'd0 && stall_req_o === 1'b0,
        "reset_in_end", {result_o[61:0], ready_o, stall_req_o}, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
